// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM scheduler and its channels.
package rgb_pwm_pkg;

   localparam int DUTY_W   = 5;
   localparam int SLOT_MAX = (2 ** DUTY_W) - 2;

   localparam int LED_R = 0;
   localparam int LED_G = 1;
   localparam int LED_B = 2;

   typedef struct packed {
      logic [DUTY_W-1:0] b;
      logic [DUTY_W-1:0] g;
      logic [DUTY_W-1:0] r;
   } rgb_duty_t;

endpackage

// File: rtl/rgb_pwm_scheduler_pwm_channel.sv
// One PWM colour channel: holds the active duty and drives the registered compare output.
// RGB_PWM_SCHEDULER_FADE_EN selects a one-step-per-frame fade instead of an instant load.
module pwm_channel #(
   parameter int DUTY_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              frame_end,
   input  logic [DUTY_W-1:0] sc,
   input  logic [DUTY_W-1:0] target,
   output logic [DUTY_W-1:0] active,
   output logic              pwm
);

   // NOTE: state registers use <= so every flop samples pre-edge values regardless of order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         active <= '0;
      end else if (frame_end) begin
`ifdef RGB_PWM_SCHEDULER_FADE_EN
         if (active < target) begin
            active <= active + 1'b1;
         end else if (active > target) begin
            active <= active - 1'b1;
         end
`else
         active <= target;
`endif
      end
   end

   // The slot counter never reaches 2**DUTY_W-1, so a full-scale duty stays high.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pwm <= 1'b0;
      end else begin
         pwm <= (sc < active);
      end
   end

endmodule

// File: rtl/rgb_pwm_scheduler.sv
// RGB PWM scheduler for LED0/LED1: SW sync, prescaler, slot counter, frame-aligned duty load.
// Optional fade build: define RGB_PWM_SCHEDULER_FADE_EN.
module rgb_pwm_scheduler #(
   parameter int DUTY_W   = 5,
   parameter int PRESCALE = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [3*DUTY_W:0]     SW,
   output logic [2:0]            LED0,
   output logic [2:0]            LED1,
   output logic                  FRAME,
   output logic [3*DUTY_W-1:0]   DUTY0,
   output logic [3*DUTY_W-1:0]   DUTY1
);
   import rgb_pwm_pkg::*;

   localparam int SW_W = 3 * DUTY_W + 1;
   localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PC_W-1:0]   PC_LAST = PC_W'(PRESCALE - 1);
   localparam logic [DUTY_W-1:0] SC_MAX  = DUTY_W'((2 ** DUTY_W) - 2);

   typedef logic [2:0][DUTY_W-1:0] duty_vec_t;

   logic [SW_W-1:0]   sw_m;
   logic [SW_W-1:0]   sw_s;
   logic [PC_W-1:0]   pc;
   logic [DUTY_W-1:0] sc;
   logic              tick;
   logic              frame_end;
   logic [1:0][2:0]   led;
   duty_vec_t [1:0]   act;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sw_m <= '0;
         sw_s <= '0;
      end else begin
         sw_m <= SW;
         sw_s <= sw_m;
      end
   end

   assign tick      = (pc == PC_LAST);
   assign frame_end = tick && (sc == SC_MAX);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc <= '0;
      end else if (tick) begin
         pc <= '0;
      end else begin
         pc <= pc + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sc <= '0;
      end else if (tick) begin
         sc <= (sc == SC_MAX) ? '0 : sc + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         FRAME <= 1'b0;
      end else begin
         FRAME <= frame_end;
      end
   end

   for (genvar l = 0; l < 2; l++) begin : g_led
      duty_vec_t tgt;
      duty_vec_t tgt_nxt;
      logic      load;

      assign load    = frame_end && (sw_s[SW_W-1] == 1'(l));
      // Channels see the value being loaded so SW reaches the active duty at the same frame end.
      assign tgt_nxt = load ? duty_vec_t'(sw_s[SW_W-2:0]) : tgt;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            tgt <= '0;
         end else begin
            tgt <= tgt_nxt;
         end
      end

      for (genvar c = 0; c < 3; c++) begin : g_ch
         pwm_channel #(.DUTY_W(DUTY_W)) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .frame_end (frame_end),
            .sc        (sc),
            .target    (tgt_nxt[c]),
            .active    (act[l][c]),
            .pwm       (led[l][c])
         );
      end
   end

   assign LED0  = led[0];
   assign LED1  = led[1];
   assign DUTY0 = act[0];
   assign DUTY1 = act[1];

endmodule

// File: tb/tb_rgb_pwm_scheduler.sv
// Self-checking bench for rgb_pwm_scheduler: duty vector table, frame scoreboard, reset/mid-frame cases.
module tb_rgb_pwm_scheduler;
   import rgb_pwm_pkg::*;

   localparam int PRESCALE   = 4;
   localparam int FRAME_CLKS = (SLOT_MAX + 1) * PRESCALE;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] SW  = '0;
   logic [2:0]  LED0, LED1;
   logic        FRAME;
   logic [14:0] DUTY0, DUTY1;

   always #5 CLK = ~CLK;

   rgb_pwm_scheduler #(.DUTY_W(DUTY_W), .PRESCALE(PRESCALE)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .SW    (SW),
      .LED0  (LED0),
      .LED1  (LED1),
      .FRAME (FRAME),
      .DUTY0 (DUTY0),
      .DUTY1 (DUTY1)
   );

   typedef struct {
      logic [15:0] sw;
      rgb_duty_t   d0;
      rgb_duty_t   d1;
   } vec_t;

   typedef struct {
      rgb_duty_t d0;
      rgb_duty_t d1;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick_s();
      @(posedge CLK);
      #1;
   endtask

   // Returns the number of rising edges until FRAME is seen, or -1 on timeout.
   task automatic wait_frame(output int n);
      n = -1;
      for (int i = 1; i <= FRAME_CLKS + 40; i++) begin
         tick_s();
         if (FRAME) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic push_exp(input rgb_duty_t d0, input rgb_duty_t d1);
      exp_t e;
      e.d0 = d0;
      e.d1 = d1;
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty at FRAME, got duty0=%0h duty1=%0h", tag, DUTY0, DUTY1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_duty0"}, 32'(DUTY0), 32'(e.d0));
         check({tag, "_duty1"}, 32'(DUTY1), 32'(e.d1));
      end
   endtask

   task automatic frame_sb(input string tag);
      int n;
      wait_frame(n);
      check({tag, "_frame_seen"}, 32'(n > 0), 32'd1);
      sb_check(tag);
   endtask

   // Counts LED high cycles over one whole frame starting one cycle after FRAME.
   task automatic measure(input string tag, input rgb_duty_t d0, input rgb_duty_t d1);
      int h0[3];
      int h1[3];
      for (int c = 0; c < 3; c++) begin
         h0[c] = 0;
         h1[c] = 0;
      end
      for (int i = 0; i < FRAME_CLKS; i++) begin
         tick_s();
         for (int c = 0; c < 3; c++) begin
            h0[c] += int'(LED0[c]);
            h1[c] += int'(LED1[c]);
         end
      end
      check({tag, "_led0_r"}, h0[LED_R], int'(d0.r) * PRESCALE);
      check({tag, "_led0_g"}, h0[LED_G], int'(d0.g) * PRESCALE);
      check({tag, "_led0_b"}, h0[LED_B], int'(d0.b) * PRESCALE);
      check({tag, "_led1_r"}, h1[LED_R], int'(d1.r) * PRESCALE);
      check({tag, "_led1_g"}, h1[LED_G], int'(d1.g) * PRESCALE);
      check({tag, "_led1_b"}, h1[LED_B], int'(d1.b) * PRESCALE);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_led0"},  32'(LED0),  32'd0);
      check({tag, "_led1"},  32'(LED1),  32'd0);
      check({tag, "_frame"}, 32'(FRAME), 32'd0);
      check({tag, "_duty0"}, 32'(DUTY0), 32'd0);
      check({tag, "_duty1"}, 32'(DUTY1), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int        n;
      int        stable;
      rgb_duty_t z;
      rgb_duty_t d1_keep;

      z = '{b: 5'd0, g: 5'd0, r: 5'd0};

      vecs[0] = '{sw: 16'h3F83, d0: '{b: 5'd15, g: 5'd28, r: 5'd3},  d1: z};
      vecs[1] = '{sw: 16'h801F, d0: '{b: 5'd15, g: 5'd28, r: 5'd3},  d1: '{b: 5'd0,  g: 5'd0,  r: 5'd31}};
      vecs[2] = '{sw: 16'hFFE0, d0: '{b: 5'd15, g: 5'd28, r: 5'd3},  d1: '{b: 5'd31, g: 5'd31, r: 5'd0}};
      vecs[3] = '{sw: 16'h0000, d0: z,                               d1: '{b: 5'd31, g: 5'd31, r: 5'd0}};
      vecs[4] = '{sw: 16'h7FFF, d0: '{b: 5'd31, g: 5'd31, r: 5'd31}, d1: '{b: 5'd31, g: 5'd31, r: 5'd0}};
      vecs[5] = '{sw: 16'h8421, d0: '{b: 5'd31, g: 5'd31, r: 5'd31}, d1: '{b: 5'd1,  g: 5'd1,  r: 5'd1}};

      // Reset state and first-frame timing.
      RST = 1'b1;
      repeat (3) tick_s();
      check_all_zero("reset");
      @(negedge CLK);
      RST = 1'b0;
      wait_frame(n);
      check("first_frame_edges", n, FRAME_CLKS);
      tick_s();
      check("frame_one_cycle", 32'(FRAME), 32'd0);

`ifndef RGB_PWM_SCHEDULER_FADE_EN
      for (int i = 0; i < 6; i++) begin
         SW = vecs[i].sw;
         push_exp(vecs[i].d0, vecs[i].d1);
         frame_sb($sformatf("vec%0d", i));
         measure($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1);
      end

      // Three mid-frame SW changes; only the last one may land, and only on LED0.
      d1_keep = vecs[5].d1;
      stable  = 1;
      for (int i = 0; i < 80; i++) begin
         if (i == 20) SW = 16'h0005;
         if (i == 50) SW = 16'h8006;
         if (i == 79) SW = 16'h0007;
         tick_s();
         if (FRAME || DUTY0 !== 15'h7FFF || DUTY1 !== 15'(d1_keep) || LED0 !== 3'b111) stable = 0;
      end
      push_exp('{b: 5'd0, g: 5'd0, r: 5'd7}, d1_keep);
      n = -1;
      for (int i = 1; i <= FRAME_CLKS + 40; i++) begin
         tick_s();
         if (FRAME) begin
            n = i;
            break;
         end
         if (DUTY0 !== 15'h7FFF || LED0 !== 3'b111) stable = 0;
      end
      check("midframe_stable", 32'(stable), 32'd1);
      check("midframe_frame_seen", 32'(n > 0), 32'd1);
      sb_check("midframe");
      check("midframe_led0_at_frame", 32'(LED0), 32'd7);
      tick_s();
      check("midframe_led0_after", 32'(LED0), 32'd1);
`else
      // Fade: one step per frame toward the target, up then down.
      SW = 16'h0008;
      for (int k = 1; k <= 10; k++) begin
         push_exp('{b: 5'd0, g: 5'd0, r: 5'((k < 8) ? k : 8)}, z);
         frame_sb($sformatf("fade_up%0d", k));
      end
      SW = 16'h0005;
      for (int k = 1; k <= 4; k++) begin
         push_exp('{b: 5'd0, g: 5'd0, r: 5'((8 - k > 5) ? 8 - k : 5)}, z);
         frame_sb($sformatf("fade_dn%0d", k));
      end
`endif

      // Asynchronous reset in mid-frame, then restart timing.
      repeat (40) tick_s();
      check("pre_reset_duty0_nonzero", 32'(DUTY0 != 15'd0), 32'd1);
      #2;
      RST = 1'b1;
      SW  = 16'h0000;
      #1;
      check_all_zero("async_reset");
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      push_exp(z, z);
      wait_frame(n);
      check("restart_frame_edges", n, FRAME_CLKS);
      sb_check("restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
